// File: rtl/spork_pkg.sv
// -----------------------------------------------------------------------------
// spork_pkg
//   Shared types and constants for the SPORK fetch front end.
//   - fetch_state_t : fetch sequencer states (IDLE, RUN, HALT)
//   - OPCODE_W / OP_MSB / OP_LSB : where the opcode sits in an instruction word
//   - HALT_OPCODE   : opcode that stops fetch
//   - DEFAULT_ADDR_W / DEFAULT_INST_W : default PC and instruction widths
//   - is_halt_opcode(), sat_inc16() : small helpers used by the sequencer
// -----------------------------------------------------------------------------
package spork_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int OPCODE_W = 4;
    localparam int OP_MSB   = 8;
    localparam int OP_LSB   = 5;

    localparam logic [OPCODE_W-1:0] HALT_OPCODE = 4'hF;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_INST_W = 9;

    localparam int CYCLE_W = 16;

    // True when an opcode field matches the supplied halt opcode.
    function automatic logic is_halt_opcode(input logic [OPCODE_W-1:0] opcode,
                                            input logic [OPCODE_W-1:0] halt_op);
        return (opcode == halt_op);
    endfunction

    // Saturating increment: sticks at all-ones instead of wrapping to zero.
    function automatic logic [CYCLE_W-1:0] sat_inc16(input logic [CYCLE_W-1:0] value);
        return (value == {CYCLE_W{1'b1}}) ? value : value + CYCLE_W'(1);
    endfunction

endpackage

// File: rtl/pc_counter.sv
// -----------------------------------------------------------------------------
// pc_counter
//   Program-counter register. Load has priority over increment; with neither
//   asserted the value is held. Increment wraps modulo 2**ADDR_W.
// Ports
//   i_clk         in   1       clock, rising edge
//   i_rst_n       in   1       asynchronous active-low reset (pc <= RESET_VALUE)
//   i_load        in   1       load i_load_value this edge
//   i_load_value  in   ADDR_W  value to load
//   i_inc         in   1       increment this edge (ignored when i_load)
//   o_pc          out  ADDR_W  current program counter
// -----------------------------------------------------------------------------
module pc_counter #(
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_VALUE = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_value,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pc <= RESET_VALUE;
        end else if (i_load) begin
            o_pc <= i_load_value;
        end else if (i_inc) begin
            o_pc <= o_pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Program-counter and fetch controller for the SPORK core. Drives the address
//   of the combinational instruction ROM and registers each returned word with a
//   valid flag for decode. Handles start, stall, taken branches and halt.
// Ports
//   i_clk            in   1       clock, rising edge
//   i_rst_n          in   1       asynchronous active-low reset
//   i_start          in   1       begin fetch at START_ADDR (honoured in IDLE/HALT)
//   i_stall          in   1       decode not ready; freeze fetch state
//   i_branch_taken   in   1       redirect for the instruction on o_inst
//   i_branch_target  in   ADDR_W  absolute branch target
//   o_rom_addr       out  ADDR_W  ROM address (the pc register)
//   i_rom_value      in   INST_W  ROM data for o_rom_addr, same cycle
//   o_inst           out  INST_W  registered instruction
//   o_inst_valid     out  1       o_inst / o_pc hold a live instruction
//   o_pc             out  ADDR_W  address o_inst was fetched from
//   o_halted         out  1       sequencer is in HALT
//   o_cycle_count    out  16      RUN cycles since last start, saturating
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int                ADDR_W      = spork_pkg::DEFAULT_ADDR_W,
    parameter int                INST_W      = spork_pkg::DEFAULT_INST_W,
    parameter logic [ADDR_W-1:0] START_ADDR  = '0,
    parameter logic [3:0]        HALT_OPCODE = spork_pkg::HALT_OPCODE
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [INST_W-1:0] i_rom_value,
    output logic [INST_W-1:0] o_inst,
    output logic              o_inst_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_halted,
    output logic [15:0]       o_cycle_count
);

    import spork_pkg::*;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;

    logic              advance;      // RUN and decode ready this cycle
    logic              take_branch;  // redirect the live instruction
    logic              take_halt;    // live instruction is a halt word
    logic              do_capture;   // register the ROM word

    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_value;
    logic              pc_inc;

    // Branch beats halt: a branch on the halt word's own valid cycle cancels it.
    // Both decisions look only at the live (valid) word, so a halt word fetched
    // in the squashed slot behind a branch is never seen here.
    assign advance     = (state == RUN) && !i_stall;
    assign take_branch = advance && o_inst_valid && i_branch_taken;
    assign take_halt   = advance && o_inst_valid && !i_branch_taken &&
                         is_halt_opcode(o_inst[OP_MSB:OP_LSB], HALT_OPCODE);
    assign do_capture  = advance && !take_branch && !take_halt;

    // NOTE: every always_comb output is given a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_load       = 1'b0;
        pc_load_value = START_ADDR;
        pc_inc        = 1'b0;
        unique case (state)
            IDLE, HALT: begin
                if (i_start) begin
                    pc_load = 1'b1;
                end
            end
            RUN: begin
                if (take_branch) begin
                    pc_load       = 1'b1;
                    pc_load_value = i_branch_target;
                end else if (do_capture) begin
                    pc_inc = 1'b1;
                end
            end
            default: begin
                pc_load = 1'b0;
            end
        endcase
    end

    pc_counter #(
        .ADDR_W      (ADDR_W),
        .RESET_VALUE (START_ADDR)
    ) u_pc_counter (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (pc_load),
        .i_load_value (pc_load_value),
        .i_inc        (pc_inc),
        .o_pc         (pc)
    );

    assign o_rom_addr = pc;

    // FSM, capture register and cycle counter. All outputs are registered here.
    // NOTE: the capture register is plain flops (not a memory), so it is reset
    // along with everything else and no stale word can appear valid after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            o_inst        <= '0;
            o_pc          <= '0;
            o_inst_valid  <= 1'b0;
            o_halted      <= 1'b0;
            o_cycle_count <= '0;
        end else begin
            unique case (state)
                IDLE, HALT: begin
                    if (i_start) begin
                        state         <= RUN;
                        o_inst_valid  <= 1'b0;
                        o_halted      <= 1'b0;
                        o_cycle_count <= '0;
                    end
                end
                RUN: begin
                    // Counts every RUN cycle, stalled or not.
                    o_cycle_count <= sat_inc16(o_cycle_count);
                    if (take_branch) begin
                        // Same-cycle ROM word is the wrong path: drop it.
                        o_inst_valid <= 1'b0;
                    end else if (take_halt) begin
                        state        <= HALT;
                        o_inst_valid <= 1'b0;
                        o_halted     <= 1'b1;
                    end else if (do_capture) begin
                        o_inst       <= i_rom_value;
                        o_pc         <= pc;
                        o_inst_valid <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    o_inst_valid <= 1'b0;
                    o_halted     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed and randomized stimulus for fetch_sequencer, checked every cycle
//   against a transaction-level reference model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_stall = 1'b0;
    logic       i_branch_taken = 1'b0;
    logic [7:0] i_branch_target = 8'h00;
    logic [7:0] o_rom_addr;
    logic [8:0] i_rom_value;
    logic [8:0] o_inst;
    logic       o_inst_valid;
    logic [7:0] o_pc;
    logic       o_halted;
    logic [15:0] o_cycle_count;

    logic [8:0] rom [256];
    assign i_rom_value = rom[o_rom_addr];

    always #5 i_clk = ~i_clk;

    fetch_sequencer dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_start         (i_start),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .o_rom_addr      (o_rom_addr),
        .i_rom_value     (i_rom_value),
        .o_inst          (o_inst),
        .o_inst_valid    (o_inst_valid),
        .o_pc            (o_pc),
        .o_halted        (o_halted),
        .o_cycle_count   (o_cycle_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: is fetch running, did it halt, next fetch address,
    // the word handed to decode and where it came from, and the RUN cycle count.
    bit         m_run, m_halt, m_valid;
    logic [7:0] m_pc, m_opc;
    logic [8:0] m_inst;
    int         m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("rom_addr", o_rom_addr, m_pc);
        check("inst_valid", o_inst_valid, m_valid);
        check("inst", o_inst, m_inst);
        check("pc", o_pc, m_opc);
        check("halted", o_halted, m_halt);
        check("cycle_count", o_cycle_count, m_cnt);
    endtask

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_valid = 0;
        m_pc = 8'h00; m_opc = 8'h00; m_inst = 9'h000; m_cnt = 0;
    endtask

    // One clock edge of the fetch rules, applied to the current inputs.
    task automatic model_edge();
        if (!m_run) begin
            if (i_start) begin
                m_run = 1; m_halt = 0; m_valid = 0; m_pc = 8'h00; m_cnt = 0;
            end
        end else begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (!i_stall) begin
                if (m_valid && i_branch_taken) begin
                    m_pc = i_branch_target;
                    m_valid = 0;
                end else if (m_valid && m_inst[8:5] == 4'hF) begin
                    m_run = 0; m_halt = 1; m_valid = 0;
                end else begin
                    m_inst = rom[m_pc];
                    m_opc = m_pc;
                    m_valid = 1;
                    m_pc = 8'((int'(m_pc) + 1) % 256);
                end
            end
        end
    endtask

    // Inputs are set one time unit after a rising edge; outputs sampled likewise.
    task automatic step();
        model_edge();
        @(posedge i_clk);
        #1;
        check_outputs();
    endtask

    task automatic run_until(input logic [7:0] addr, input int budget);
        bit found;
        found = 0;
        for (int k = 0; k < budget; k++) begin
            if (m_valid && m_opc == addr) begin
                found = 1;
                break;
            end
            step();
        end
        if (m_valid && m_opc == addr) found = 1;
        check("reach_pc", found, 1'b1);
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs();
        @(posedge i_clk);
        #1;
        check_outputs();
        i_rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic branch_to(input logic [7:0] target);
        i_branch_taken = 1'b1;
        i_branch_target = target;
        step();
        i_branch_taken = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [8:0] v;
        logic [8:0] t1_words [4];
        int base;

        for (int i = 0; i < 256; i++) begin
            v = 9'($urandom);
            if (v[8:5] == 4'hF) v[8] = 1'b0;
            rom[i] = v;
        end
        t1_words[0] = 9'h012; t1_words[1] = 9'h034;
        t1_words[2] = 9'h056; t1_words[3] = 9'h078;
        for (int i = 0; i < 4; i++) rom[i] = t1_words[i];
        rom[8'h0A] = 9'h1E0;

        model_reset();
        #3;
        apply_reset();

        // 1. Start: first valid word on the second edge after the start pulse.
        pulse_start();
        check("t1_bubble", o_inst_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t1_pc", o_pc, 8'(k));
            check("t1_inst", o_inst, t1_words[k]);
            check("t1_rom_addr", o_rom_addr, 8'(k + 1));
        end

        // 2. Branch on the word at 0x05 to 0x40: one bubble then the target.
        run_until(8'h05, 10);
        branch_to(8'h40);
        check("t2_bubble", o_inst_valid, 1'b0);
        step();
        check("t2_pc", o_pc, 8'h40);
        check("t2_inst", o_inst, rom[8'h40]);
        check("t2_rom_addr", o_rom_addr, 8'h41);

        // 3. Stall three cycles on the word at 0x07.
        apply_reset();
        pulse_start();
        run_until(8'h07, 20);
        base = m_cnt;
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_frozen_pc", o_pc, 8'h07);
            check("t3_frozen_valid", o_inst_valid, 1'b1);
        end
        check("t3_count", o_cycle_count, 16'(base + 3));
        i_stall = 1'b0;
        step();
        check("t3_next_pc", o_pc, 8'h08);

        // 4. Halt word at 0x0A, stays halted, restart clears the count.
        run_until(8'h0A, 10);
        check("t4_halt_word", o_inst, 9'h1E0);
        step();
        check("t4_halted", o_halted, 1'b1);
        for (int k = 0; k < 20; k++) begin
            step();
            check("t4_pc_frozen", o_rom_addr, 8'h0B);
        end
        pulse_start();
        check("t4_restart_addr", o_rom_addr, 8'h00);
        check("t4_count_clear", o_cycle_count, 16'h0000);

        // 5. Halt word in the squashed slot, then wrap past 0xFF.
        run_until(8'h09, 20);
        branch_to(8'h20);
        step();
        check("t5_target_pc", o_pc, 8'h20);
        for (int k = 0; k < 5; k++) step();
        check("t5_no_halt", o_halted, 1'b0);
        branch_to(8'hFE);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t5_wrap_pc", o_pc, 8'(8'hFE + k));
        end

        // 6. Asynchronous reset mid-RUN, away from the clock edge.
        for (int k = 0; k < 3; k++) step();
        model_edge();
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge i_clk);
        #1;
        check_outputs();
        i_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("t6_idle_valid", o_inst_valid, 1'b0);

        // Randomized traffic: stalls, branches (some on invalid cycles), and
        // start pulses that only matter in IDLE/HALT.
        pulse_start();
        for (int k = 0; k < 500; k++) begin
            i_stall = ($urandom_range(0, 99) < 30);
            i_branch_taken = ($urandom_range(0, 99) < 15);
            i_branch_target = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
            i_start = ($urandom_range(0, 99) < 8);
            step();
        end
        i_stall = 1'b0;
        i_branch_taken = 1'b0;
        i_start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
